// File: rtl/meta_intf_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// meta_intf_wrr_arbiter
//
// Weighted round-robin arbiter merging N_INTERFACES valid/ready request streams
// onto one registered output stream. A grant serves one input for up to
// weight[i] consecutive beats, then hands over to the next eligible input
// (round-robin from the input after the last one served). A weight of 0
// disables that input.
//
// Ports
//   clk              : clock, all logic on the rising edge
//   rst_n            : asynchronous active-low reset
//   i_intf_in_valid  : per-input valid
//   o_intf_in_ready  : per-input ready (combinational, at most one high)
//   i_intf_in_data   : per-input data (STYPE)
//   o_intf_out_valid : registered output valid
//   i_intf_out_ready : downstream ready
//   o_intf_out_data  : registered output data (not reset)
//   o_out_src        : index of the input that produced the output beat
//   i_cfg_valid      : one-cycle strobe loading i_cfg_weight into the weights
//   i_cfg_weight     : packed per-input weights, input k at [k*WEIGHT_BITS +:]
//   o_busy           : high while a grant is active
// -----------------------------------------------------------------------------
module meta_intf_wrr_arbiter #(
  parameter int  N_INTERFACES = 4,
  parameter type STYPE        = logic [63:0],
  parameter int  WEIGHT_BITS  = 4,
  localparam int ID_BITS      = (N_INTERFACES > 1) ? $clog2(N_INTERFACES) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_INTERFACES-1:0]             i_intf_in_valid,
  output logic [N_INTERFACES-1:0]             o_intf_in_ready,
  input  STYPE                                i_intf_in_data [N_INTERFACES],
  output logic                                o_intf_out_valid,
  input  logic                                i_intf_out_ready,
  output STYPE                                o_intf_out_data,
  output logic [ID_BITS-1:0]                  o_out_src,
  input  logic                                i_cfg_valid,
  input  logic [N_INTERFACES*WEIGHT_BITS-1:0] i_cfg_weight,
  output logic                                o_busy
);

  typedef enum logic {ST_ARB = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WEIGHT_BITS-1:0] r_weight [N_INTERFACES];
  logic [ID_BITS-1:0]     r_rr_ptr;
  logic [ID_BITS-1:0]     r_cur;
  logic [WEIGHT_BITS-1:0] r_limit;
  logic [WEIGHT_BITS-1:0] r_beat_cnt;
  logic                   r_out_valid;
  logic [ID_BITS-1:0]     r_out_src;
  STYPE                   r_out_data;

  logic                   w_slot_accept;
  logic                   w_cur_valid;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_release;
  logic                   w_sel_found;
  logic [ID_BITS-1:0]     w_sel_idx;
  logic [ID_BITS-1:0]     w_cur_inc;
  int                     w_scan;

  // The output register can take a new beat when it is empty or being drained.
  assign w_slot_accept = !r_out_valid || i_intf_out_ready;
  assign w_cur_valid   = i_intf_in_valid[r_cur];
  assign w_xfer        = (r_state == ST_GRANT) && w_cur_valid && w_slot_accept;
  assign w_last        = w_xfer && (r_beat_cnt == (r_limit - 1'b1));
  // A requester that goes idle while the slot could accept loses its grant;
  // a stalled slot never releases, so backpressure cannot cost a grant.
  assign w_release     = (r_state == ST_GRANT) &&
                         (w_last || (w_slot_accept && !w_cur_valid));
  assign w_cur_inc     = (r_cur == ID_BITS'(N_INTERFACES - 1)) ? '0 : r_cur + 1'b1;

  // Round-robin scan starting at r_rr_ptr; first valid input with nonzero weight.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_scan      = 0;
    for (int k = 0; k < N_INTERFACES; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= N_INTERFACES) w_scan = w_scan - N_INTERFACES;
      if (!w_sel_found && i_intf_in_valid[w_scan] && (r_weight[w_scan] != '0)) begin
        w_sel_found = 1'b1;
        w_sel_idx   = ID_BITS'(w_scan);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ARB;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARB:   if (w_sel_found) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_release)   w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_ARB;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_intf_in_ready = '0;
    if ((r_state == ST_GRANT) && w_slot_accept) o_intf_in_ready[r_cur] = 1'b1;
    o_busy = (r_state == ST_GRANT);
  end

  // Grant bookkeeping, output control and shadow weights
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_cur       <= '0;
      r_limit     <= '0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      for (int k = 0; k < N_INTERFACES; k++) r_weight[k] <= WEIGHT_BITS'(1);
    end else begin
      // The limit is latched at selection, so later weight updates only
      // affect the next grant.
      if ((r_state == ST_ARB) && w_sel_found) begin
        r_cur      <= w_sel_idx;
        r_limit    <= r_weight[w_sel_idx];
        r_beat_cnt <= '0;
      end else if (w_xfer) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_release) r_rr_ptr <= w_cur_inc;
      if (w_slot_accept) r_out_valid <= w_xfer;
      if (w_xfer) r_out_src <= r_cur;
      if (i_cfg_valid) begin
        for (int k = 0; k < N_INTERFACES; k++)
          r_weight[k] <= i_cfg_weight[k*WEIGHT_BITS +: WEIGHT_BITS];
      end
    end
  end

  // Output data register, deliberately left without reset
  always_ff @(posedge clk) begin
    if (w_xfer) r_out_data <= i_intf_in_data[r_cur];
  end

  assign o_intf_out_valid = r_out_valid;
  assign o_intf_out_data  = r_out_data;
  assign o_out_src        = r_out_src;

endmodule

// File: tb/tb_meta_intf_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_meta_intf_wrr_arbiter
//
// Drives four requesters with tagged data ({src, seq}) and checks every cycle
// against a transaction-level model of the weighted round-robin rules:
// grant selection, grant length, release, output slot occupancy and data.
// Directed scenarios cover the equal-weight rotation, a weighted round, an
// early-ending requester, a backpressure stall and reset during a grant.
// -----------------------------------------------------------------------------
module tb_meta_intf_wrr_arbiter;

  localparam int N  = 4;
  localparam int WB = 4;
  localparam int ID = 2;
  typedef logic [15:0] data_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  data_t         in_data [N];
  logic          out_valid;
  logic          out_ready;
  data_t         out_data;
  logic [ID-1:0] out_src;
  logic          cfg_valid;
  logic [N*WB-1:0] cfg_weight;
  logic          busy;

  always #5 clk = ~clk;

  meta_intf_wrr_arbiter #(
    .N_INTERFACES (N),
    .STYPE        (data_t),
    .WEIGHT_BITS  (WB)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_intf_in_valid  (in_valid),
    .o_intf_in_ready  (in_ready),
    .i_intf_in_data   (in_data),
    .o_intf_out_valid (out_valid),
    .i_intf_out_ready (out_ready),
    .o_intf_out_data  (out_data),
    .o_out_src        (out_src),
    .i_cfg_valid      (cfg_valid),
    .i_cfg_weight     (cfg_weight),
    .o_busy           (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stimulus state
  int in_seq  [N];
  bit in_v    [N];
  int in_left [N];
  int p_valid, p_ready, p_cfg;
  int hold_low;
  int src_log [$];

  // Reference model state
  int m_w [N];
  int m_rr, m_cur, m_lim, m_cnt, m_osrc, m_odata;
  bit m_grant, m_ov;

  function automatic int tag_of(input int src, input int seq);
    return src * 4096 + (seq % 4096);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = in_v[i];
      in_data[i]  = data_t'(tag_of(i, in_seq[i]));
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_rr = 0; m_cur = 0; m_lim = 0; m_cnt = 0;
    m_ov = 0; m_osrc = 0; m_odata = 0;
    for (int i = 0; i < N; i++) m_w[i] = 1;
  endtask

  // One clock: compare at the falling edge, advance the model to the state
  // after the next rising edge, then drive new stimulus just after that edge.
  task automatic step();
    bit sa, xfer, exp_r;
    bit acc [N];
    @(negedge clk);
    sa = !m_ov || out_ready;
    check("out_valid", out_valid, m_ov);
    check("busy", busy, m_grant);
    if (m_ov) begin
      check("out_src", out_src, m_osrc);
      check("out_data", out_data, m_odata);
    end
    for (int i = 0; i < N; i++) begin
      exp_r = m_grant && (i == m_cur) && sa;
      check($sformatf("in_ready%0d", i), in_ready[i], exp_r);
      acc[i] = in_valid[i] && in_ready[i];
    end
    if (m_ov && out_ready) src_log.push_back(m_osrc);

    if (!m_grant) begin
      if (sa) m_ov = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (in_v[j] && m_w[j] != 0) begin
          m_grant = 1; m_cur = j; m_lim = m_w[j]; m_cnt = 0;
          break;
        end
      end
    end else begin
      xfer = in_v[m_cur] && sa;
      if (xfer) begin
        m_ov = 1; m_osrc = m_cur; m_odata = tag_of(m_cur, in_seq[m_cur]);
        m_cnt++;
      end else if (sa) begin
        m_ov = 0;
      end
      if ((xfer && m_cnt == m_lim) || (sa && !in_v[m_cur])) begin
        m_grant = 0;
        m_rr = (m_cur + 1) % N;
      end
    end
    if (cfg_valid)
      for (int i = 0; i < N; i++) m_w[i] = (cfg_weight >> (i * WB)) & 15;

    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        in_seq[i]++;
        in_left[i]--;
        in_v[i] = 0;
      end
      if (!in_v[i] && in_left[i] > 0 && $urandom_range(99) < p_valid) in_v[i] = 1;
    end
    if (hold_low > 0) begin
      out_ready = 1'b0;
      hold_low--;
    end else begin
      out_ready = ($urandom_range(99) < p_ready);
    end
    if (p_cfg > 0 && $urandom_range(99) < p_cfg) begin
      cfg_valid  = 1'b1;
      cfg_weight = 16'($urandom);
    end else begin
      cfg_valid  = 1'b0;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_src", out_src, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic set_all(input bit v, input int left);
    for (int i = 0; i < N; i++) begin
      in_v[i] = v;
      in_left[i] = left;
    end
    drive();
  endtask

  task automatic check_log(input string tag, input int exp []);
    check({tag, "_len"}, (src_log.size() >= exp.size()) ? 1 : 0, 1);
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s_src%0d", tag, k), (k < src_log.size()) ? src_log[k] : -1, exp[k]);
  endtask

  initial begin
    bit found;
    cfg_valid = 1'b0; cfg_weight = '0; out_ready = 1'b0;
    p_valid = 100; p_ready = 100; p_cfg = 0; hold_low = 0;
    for (int i = 0; i < N; i++) begin
      in_seq[i] = 0; in_v[i] = 0; in_left[i] = 0;
    end
    drive();
    model_reset();
    pulse_reset();

    // Equal weights, everyone valid: strict rotation with one bubble per beat
    set_all(1, 1000);
    out_ready = 1'b1;
    src_log.delete();
    run(14);
    check_log("rot", '{0, 1, 2, 3, 0});

    // Downstream stall for five cycles in the middle of traffic
    hold_low = 5;
    run(12);

    // Weighted round {3,1,0,2}
    pulse_reset();
    set_all(0, 1000);
    cfg_valid = 1'b1;
    cfg_weight = {4'd2, 4'd0, 4'd1, 4'd3};
    out_ready = 1'b1;
    step();
    set_all(1, 1000);
    src_log.delete();
    run(24);
    check_log("wrr", '{0, 0, 0, 1, 3, 3, 0, 0, 0});

    // Input 1 alone with weight 4 but only two beats to send
    pulse_reset();
    set_all(0, 0);
    cfg_valid = 1'b1;
    cfg_weight = {4'd1, 4'd1, 4'd4, 4'd1};
    out_ready = 1'b1;
    step();
    in_left[1] = 2;
    in_v[1] = 1;
    drive();
    src_log.delete();
    run(10);
    check("early_len", src_log.size(), 2);
    check_log("early", '{1, 1});
    check("early_idle_ready", in_ready, 0);
    check("early_idle_busy", busy, 0);
    set_all(1, 1);
    src_log.delete();
    run(12);
    check_log("after_early", '{2, 3, 0, 1});

    // Randomized traffic, backpressure and weight updates
    pulse_reset();
    p_valid = 60; p_ready = 70; p_cfg = 5;
    set_all(0, 100000);
    run(1500);

    // Reset while a grant has a beat sitting in the output register
    p_ready = 30;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      step();
      if (m_grant && m_ov) found = 1;
    end
    check("mid_grant_found", found, 1);
    pulse_reset();
    p_ready = 70;
    run(500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
